pc_gen: RTL and testbench

Program-counter generator that sits directly upstream of the fetch stage in the 64-bit in-order pipeline. It owns the architectural fetch PC, advances it sequentially, and applies branch/jump redirects from execute. Because the instruction-bus address must stay stable while a request is outstanding, it defers redirects that arrive mid-request. It raises a squash flag so the stale instruction returned by that request never reaches decode.

---
 rtl/pc_gen.sv | 116 +++++++++++
 tb/tb_pc_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator with deferred redirects
// Optional misaligned-target trap: PCGEN_MISALIGN_CHECK_EN
module pc_gen #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallI,
   input  logic        stall_down,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] pc,
   output logic        pc_valid,
   output logic        kill_f,
   output logic        misalign
);

   localparam logic [63:0] STEP = 64'(PC_STEP);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] pend_pc_q, pend_pc_d;
   logic        pc_valid_q, pc_valid_d;
   logic        advance;
   logic        load;
   logic [63:0] target;
   logic        halted;

`ifdef PCGEN_MISALIGN_CHECK_EN
   logic        misalign_q, misalign_d;
   assign halted   = misalign_q;
   assign misalign = misalign_q;
`else
   assign halted   = 1'b0;
   assign misalign = 1'b0;
`endif

   assign advance  = !stallI && !stall_down;
   assign pc       = pc_q;
   assign pc_valid = pc_valid_q;
   assign kill_f   = (state_q == PEND);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      pc_valid_d = pc_valid_q;
      load       = 1'b0;
      target     = pc_q;
`ifdef PCGEN_MISALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         RUN: begin
            if (redirect_valid && !stallI) begin
               load   = 1'b1;
               target = redirect_pc;
            end else if (redirect_valid) begin
               // Bus address must stay put until the outstanding request completes.
               pend_pc_d = redirect_pc;
               state_d   = PEND;
            end else if (!pc_valid_q) begin
               // No fetch was issued at pc yet, so it must not be skipped.
               pc_valid_d = !halted;
            end else if (advance) begin
               pc_d = pc_q + STEP;
            end
         end
         PEND: begin
            if (!stallI) begin
               load    = 1'b1;
               target  = pend_pc_q;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      if (load) begin
         pc_d = target;
`ifdef PCGEN_MISALIGN_CHECK_EN
         misalign_d = |target[1:0];
         pc_valid_d = ~|target[1:0];
`else
         pc_valid_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         pend_pc_q  <= 64'h0;
         pc_valid_q <= 1'b0;
`ifdef PCGEN_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         pc_valid_q <= pc_valid_d;
`ifdef PCGEN_MISALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallI;
   logic        stall_down;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] pc;
   logic        pc_valid;
   logic        kill_f;
   logic        misalign;

   int n_checks = 0;
   int n_errors = 0;

   pc_gen dut (
      .clk            (clk),
      .reset          (reset),
      .stallI         (stallI),
      .stall_down     (stall_down),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .kill_f         (kill_f),
      .misalign       (misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [63:0] epc, input logic ev,
                            input logic ek, input logic em);
      check({tag, ".pc"}, pc, epc);
      check({tag, ".valid"}, 64'(pc_valid), 64'(ev));
      check({tag, ".kill"}, 64'(kill_f), 64'(ek));
      check({tag, ".mis"}, 64'(misalign), 64'(em));
   endtask

   initial begin
      reset = 1'b1; stallI = 1'b0; stall_down = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 64'h0;
      step(); step();
      chk_state("reset", 64'h8000_0000, 1'b0, 1'b0, 1'b0);

      reset = 1'b0;
      step(); chk_state("seq0", 64'h8000_0000, 1'b1, 1'b0, 1'b0);
      step(); check("seq1", pc, 64'h8000_0004);
      step(); check("seq2", pc, 64'h8000_0008);
      step(); check("seq3", pc, 64'h8000_000C);
      step(); check("seq4", pc, 64'h8000_0010);

      stall_down = 1'b1;
      step(); chk_state("sd0", 64'h8000_0010, 1'b1, 1'b0, 1'b0);
      step(); chk_state("sd1", 64'h8000_0010, 1'b1, 1'b0, 1'b0);
      stall_down = 1'b0;
      step(); check("sd_rel", pc, 64'h8000_0014);

      stall_down = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
      step(); check("redir_sd", pc, 64'h8000_0100);
      stall_down = 1'b0; redirect_valid = 1'b0;

      stallI = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
      step(); chk_state("pend0", 64'h8000_0100, 1'b1, 1'b1, 1'b0);
      redirect_pc = 64'h8000_0300;
      step(); chk_state("pend1", 64'h8000_0100, 1'b1, 1'b1, 1'b0);
      redirect_valid = 1'b0;
      step(); chk_state("pend2", 64'h8000_0100, 1'b1, 1'b1, 1'b0);
      stallI = 1'b0; stall_down = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
      step(); chk_state("pend_exit", 64'h8000_0200, 1'b1, 1'b0, 1'b0);
      redirect_valid = 1'b0; stall_down = 1'b0;
      step(); check("post_pend", pc, 64'h8000_0204);

      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step(); check("wrap_set", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      redirect_valid = 1'b0;
      step(); chk_state("wrap", 64'h0, 1'b1, 1'b0, 1'b0);

      stallI = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1000;
      step(); check("rst_pend.kill", 64'(kill_f), 64'd1);
      redirect_valid = 1'b0; reset = 1'b1;
      step(); chk_state("rst_mid", 64'h8000_0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0; stallI = 1'b0;
      step(); chk_state("rst_rel", 64'h8000_0000, 1'b1, 1'b0, 1'b0);
      step(); check("rst_adv", pc, 64'h8000_0004);

      redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
`ifdef PCGEN_MISALIGN_CHECK_EN
      step(); chk_state("mis_set", 64'h8000_0102, 1'b0, 1'b0, 1'b1);
      redirect_valid = 1'b0;
      step(); chk_state("mis_hold", 64'h8000_0102, 1'b0, 1'b0, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0104;
      step(); chk_state("mis_clr", 64'h8000_0104, 1'b1, 1'b0, 1'b0);
      stallI = 1'b1; redirect_pc = 64'h8000_0201;
      step(); check("mis_pend.kill", 64'(kill_f), 64'd1);
      redirect_valid = 1'b0; stallI = 1'b0;
      step(); chk_state("mis_pend", 64'h8000_0201, 1'b0, 1'b0, 1'b1);
`else
      step(); chk_state("unal", 64'h8000_0102, 1'b1, 1'b0, 1'b0);
      redirect_valid = 1'b0;
      step(); check("unal_adv", pc, 64'h8000_0106);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
